// File: rtl/a51_keystream_gen_if.sv
// A5/1 keystream port bundle: start/key/frame control in, handshaked keystream out.
// Latency: none, wires only.
// Backpressure: ks_ready from the consumer holds the keystream; start is only honoured while idle.
interface a51_keystream_gen_if #(
   parameter int KEY_BITS   = 64,
   parameter int FRAME_BITS = 22
);
   logic                  start;
   logic [KEY_BITS-1:0]   key;
   logic [FRAME_BITS-1:0] frame;
   logic                  busy;
   logic                  ks_bit;
   logic                  ks_valid;
   logic                  ks_ready;
   logic                  done;

   // Controller/consumer side
   modport master (
      output start, key, frame, ks_ready,
      input  busy, ks_bit, ks_valid, done
   );

   // Generator side
   modport slave (
      input  start, key, frame, ks_ready,
      output busy, ks_bit, ks_valid, done
   );
endinterface

// File: rtl/a51_keystream_gen.sv
// A5/1 keystream generator: 19/22/23-bit LFSRs, key/frame load, warm-up, then KS_BITS handshaked bits.
// Latency: start accepted in cycle 0 -> first ks_valid in cycle 1+KEY_BITS+FRAME_BITS+WARMUP+1.
// Backpressure: ks_ready low freezes registers and ks_bit; optional debug taps under A51_DBG_EN.
module a51_keystream_gen #(
   parameter int KEY_BITS   = 64,
   parameter int FRAME_BITS = 22,
   parameter int WARMUP     = 100,
   parameter int KS_BITS    = 228
) (
   input  logic                clk,
   input  logic                rst_n,
   a51_keystream_gen_if.slave  ks
`ifdef A51_DBG_EN
   ,
   output logic [18:0]         dbg_r1,
   output logic [21:0]         dbg_r2,
   output logic [22:0]         dbg_r3,
   output logic [2:0]          dbg_step,
   output logic [2:0]          dbg_state
`endif
);

   // Counter must cover the longest phase without wrapping.
   localparam int MAX_A   = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
   localparam int MAX_B   = ((WARMUP + 1) > KS_BITS) ? (WARMUP + 1) : KS_BITS;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP);
   localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD_KEY   = 3'd1,
      S_LOAD_FRAME = 3'd2,
      S_WARMUP     = 3'd3,
      S_STREAM     = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [18:0]           r1;
   logic [21:0]           r2;
   logic [22:0]           r3;
   logic [CNT_W-1:0]      cnt;
   logic [KEY_BITS-1:0]   key_sr;
   logic [FRAME_BITS-1:0] frame_sr;

   logic                  c1, c2, c3, maj;
   logic [2:0]            maj_en;
   logic                  fb1, fb2, fb3;
   logic                  hs;
   logic                  accept;

   logic                  busy_o;
   logic                  valid_o;
   logic                  done_o;
   logic [2:0]            step_en;
   logic                  load_bit;
   logic                  cnt_inc;

   // Clocking bits and majority vote; a register steps when its bit agrees with the majority.
   assign c1     = r1[8];
   assign c2     = r2[10];
   assign c3     = r3[10];
   assign maj    = (c1 & c2) | (c1 & c3) | (c2 & c3);
   assign maj_en = {c3 == maj, c2 == maj, c1 == maj};

   // Feedback taps of each register.
   assign fb1 = r1[18] ^ r1[17] ^ r1[16] ^ r1[13];
   assign fb2 = r2[21] ^ r2[20];
   assign fb3 = r3[22] ^ r3[21] ^ r3[20] ^ r3[7];

   assign accept = (state == S_IDLE) && ks.start;
   assign hs     = (state == S_STREAM) && ks.ks_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: each phase ends when the counter reaches its last index.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (ks.start)              state_nxt = S_LOAD_KEY;
         S_LOAD_KEY:   if (cnt == KEY_LAST)       state_nxt = S_LOAD_FRAME;
         S_LOAD_FRAME: if (cnt == FRAME_LAST)     state_nxt = S_WARMUP;
         S_WARMUP:     if (cnt == WARM_LAST)      state_nxt = S_STREAM;
         S_STREAM:     if (hs && cnt == KS_LAST)  state_nxt = S_DONE;
         S_DONE:                                  state_nxt = S_IDLE;
         default:                                 state_nxt = S_IDLE;
      endcase
   end

   // Outputs and datapath controls decoded from the current state.
   always_comb begin
      busy_o   = 1'b0;
      valid_o  = 1'b0;
      done_o   = 1'b0;
      step_en  = 3'b000;
      load_bit = 1'b0;
      cnt_inc  = 1'b0;
      case (state)
         S_LOAD_KEY: begin
            busy_o   = 1'b1;
            step_en  = 3'b111;
            load_bit = key_sr[0];
            cnt_inc  = 1'b1;
         end
         S_LOAD_FRAME: begin
            busy_o   = 1'b1;
            step_en  = 3'b111;
            load_bit = frame_sr[0];
            cnt_inc  = 1'b1;
         end
         S_WARMUP: begin
            busy_o   = 1'b1;
            step_en  = maj_en;
            cnt_inc  = 1'b1;
         end
         S_STREAM: begin
            busy_o   = 1'b1;
            valid_o  = 1'b1;
            step_en  = hs ? maj_en : 3'b000;
            cnt_inc  = hs;
         end
         S_DONE: begin
            done_o   = 1'b1;
         end
         default: begin
            busy_o   = 1'b0;
         end
      endcase
   end

   // LFSR stepping; load bits are injected into bit 0 after the regular step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1       <= '0;
         r2       <= '0;
         r3       <= '0;
         key_sr   <= '0;
         frame_sr <= '0;
      end else if (accept) begin
         r1       <= '0;
         r2       <= '0;
         r3       <= '0;
         key_sr   <= ks.key;
         frame_sr <= ks.frame;
      end else begin
         if (step_en[0]) r1 <= {r1[17:0], fb1 ^ load_bit};
         if (step_en[1]) r2 <= {r2[20:0], fb2 ^ load_bit};
         if (step_en[2]) r3 <= {r3[21:0], fb3 ^ load_bit};
         if (state == S_LOAD_KEY)   key_sr   <= key_sr >> 1;
         if (state == S_LOAD_FRAME) frame_sr <= frame_sr >> 1;
      end
   end

   // Phase counter: cleared on every state change, so each phase starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state_nxt != state) begin
         cnt <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign ks.busy     = busy_o;
   assign ks.ks_valid = valid_o;
   assign ks.done     = done_o;
   assign ks.ks_bit   = r1[18] ^ r2[21] ^ r3[22];

`ifdef A51_DBG_EN
   assign dbg_r1    = r1;
   assign dbg_r2    = r2;
   assign dbg_r3    = r3;
   assign dbg_step  = step_en;
   assign dbg_state = state;
`endif

endmodule

// File: tb/tb_a51_keystream_gen.sv
// Directed bench for a51_keystream_gen against the published A5/1 vector.
// Covers reset, latency, backpressure, start-while-busy, reset mid-stream and start held through done.
// Expected keystream comes from the reference vector constant.
module tb_a51_keystream_gen;

   logic clk;
   logic rst_n;

   a51_keystream_gen_if #(.KEY_BITS(64), .FRAME_BITS(22)) ks_if ();

`ifdef A51_DBG_EN
   logic [18:0] dbg_r1;
   logic [21:0] dbg_r2;
   logic [22:0] dbg_r3;
   logic [2:0]  dbg_step;
   logic [2:0]  dbg_state;
`endif

   a51_keystream_gen #(
      .KEY_BITS   (64),
      .FRAME_BITS (22),
      .WARMUP     (100),
      .KS_BITS    (228)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ks    (ks_if.slave)
`ifdef A51_DBG_EN
      ,
      .dbg_r1    (dbg_r1),
      .dbg_r2    (dbg_r2),
      .dbg_r3    (dbg_r3),
      .dbg_step  (dbg_step),
      .dbg_state (dbg_state)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   localparam logic [63:0] KEY_V   = 64'hEFCDAB8967452312;
   localparam logic [21:0] FRAME_V = 22'h134;

   // Modes: 0 ready=1, 1 random ready, 2 extra start in cycle 50, 3 reset at bit 40, 4 start held high.
   task automatic do_run(input int mode, input logic [63:0] k, input logic [21:0] f,
                         output logic [227:0] bits, output int nbits,
                         output int t_valid, output int t_done);
      int   c;
      int   last_stall;
      bit   fin;
      bit   prev_stall;
      logic prev_bit;
      bits = '0; nbits = 0; t_valid = -1; t_done = -1;
      fin = 0; prev_stall = 0; prev_bit = 1'b0; last_stall = 0;
      @(negedge clk);
      ks_if.start    = 1'b1;
      ks_if.key      = k;
      ks_if.frame    = f;
      ks_if.ks_ready = 1'b1;
      c = 0;
      while (!fin && c < 3000) begin
         @(negedge clk);
         c++;
         if (mode != 4) ks_if.start = 1'b0;
         if (mode == 2 && c == 1) begin
            ks_if.key   = ~k;
            ks_if.frame = ~f;
         end
         if (mode == 2 && c == 50) begin
            ks_if.start = 1'b1;
            ks_if.key   = 64'h0;
         end
         if (c == 1) check("busy_after_start", ks_if.busy, 1'b1);
         if (ks_if.ks_valid && t_valid < 0) t_valid = c;
         if (prev_stall) begin
            check("ks_bit_hold", ks_if.ks_bit, prev_bit);
            check("ks_valid_hold", ks_if.ks_valid, 1'b1);
         end
         prev_stall = 0;
         if (ks_if.done) begin
            t_done = c;
            fin    = 1;
            check("busy_in_done", ks_if.busy, 1'b0);
            check("valid_in_done", ks_if.ks_valid, 1'b0);
         end else if (ks_if.ks_valid) begin
            if (mode == 3 && nbits == 40) begin
               rst_n = 1'b0;
               #1;
               check("rst_busy", ks_if.busy, 1'b0);
               check("rst_valid", ks_if.ks_valid, 1'b0);
               check("rst_done", ks_if.done, 1'b0);
               check("rst_ks_bit", ks_if.ks_bit, 1'b0);
               @(negedge clk);
               check("rst_hold_valid", ks_if.ks_valid, 1'b0);
               rst_n = 1'b1;
               fin   = 1;
            end else begin
               if (mode == 1) begin
                  if (nbits == 227 && last_stall < 3) begin
                     ks_if.ks_ready = 1'b0;
                     last_stall++;
                  end else begin
                     ks_if.ks_ready = 1'($urandom_range(0, 1));
                  end
               end else begin
                  ks_if.ks_ready = 1'b1;
               end
               if (ks_if.ks_ready) begin
                  bits[227 - nbits] = ks_if.ks_bit;
                  nbits++;
               end else begin
                  prev_stall = 1;
                  prev_bit   = ks_if.ks_bit;
               end
            end
         end
      end
      if (!fin) check("run_timeout", 1'b0, 1'b1);
      if (mode != 4) ks_if.start = 1'b0;
      ks_if.ks_ready = 1'b1;
   endtask

   logic [119:0] ab_v;
   logic [227:0] ref_bits;
   logic [227:0] run_bits;
   logic [7:0]   first8;
   int           nb, tv, td;

   initial begin
      ab_v   = 120'h534EAA582FE8151AB6E1855A728C00;
      first8 = 8'b01010011;
      ks_if.start    = 1'b0;
      ks_if.key      = '0;
      ks_if.frame    = '0;
      ks_if.ks_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("reset_busy", ks_if.busy, 1'b0);
      check("reset_valid", ks_if.ks_valid, 1'b0);
      check("reset_done", ks_if.done, 1'b0);
      check("reset_ks_bit", ks_if.ks_bit, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_busy", ks_if.busy, 1'b0);
      check("idle_valid", ks_if.ks_valid, 1'b0);
      check("idle_done", ks_if.done, 1'b0);

      // Reference run with ks_ready held high.
      do_run(0, KEY_V, FRAME_V, run_bits, nb, tv, td);
      ref_bits = run_bits;
      check("vec_first8", run_bits[227:220], first8);
      check("vec_first114", run_bits[227:114], ab_v[119:6]);
      check("vec_nbits", nb, 228);
      check("lat_valid", tv, 188);
      check("lat_done", td, 416);
      @(negedge clk);
      check("busy_417", ks_if.busy, 1'b0);
      check("done_pulse_end", ks_if.done, 1'b0);

      // Random backpressure, including a stall on the last bit.
      do_run(1, KEY_V, FRAME_V, run_bits, nb, tv, td);
      check("bp_nbits", nb, 228);
      check("bp_first114", run_bits[227:114], ab_v[119:6]);
      check("bp_last114", run_bits[113:0], ref_bits[113:0]);
      @(negedge clk);

      // Start while busy and input changes after acceptance.
      do_run(2, KEY_V, FRAME_V, run_bits, nb, tv, td);
      check("sb_first114", run_bits[227:114], ab_v[119:6]);
      check("sb_last114", run_bits[113:0], ref_bits[113:0]);
      check("sb_lat_done", td, 416);

      // Fresh run right after done.
      do_run(0, KEY_V, FRAME_V, run_bits, nb, tv, td);
      check("again_first114", run_bits[227:114], ab_v[119:6]);
      check("again_last114", run_bits[113:0], ref_bits[113:0]);
      check("again_lat_valid", tv, 188);
      @(negedge clk);

      // Reset mid-stream, then a full run from bit 0.
      do_run(3, KEY_V, FRAME_V, run_bits, nb, tv, td);
      check("rst_prefix40", run_bits[227:188], ab_v[119:80]);
      do_run(0, KEY_V, FRAME_V, run_bits, nb, tv, td);
      check("post_rst_first114", run_bits[227:114], ab_v[119:6]);
      check("post_rst_last114", run_bits[113:0], ref_bits[113:0]);
      check("post_rst_lat_done", td, 416);
      @(negedge clk);

      // Start held through done restarts in the following idle cycle.
      do_run(4, KEY_V, FRAME_V, run_bits, nb, tv, td);
      check("hold_first114", run_bits[227:114], ab_v[119:6]);
      check("hold_lat_done", td, 416);
      @(negedge clk);
      check("hold_idle_busy", ks_if.busy, 1'b0);
      check("hold_idle_done", ks_if.done, 1'b0);
      @(negedge clk);
      check("hold_restart_busy", ks_if.busy, 1'b1);
      ks_if.start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("final_idle_busy", ks_if.busy, 1'b0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
